// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant locking. The owner keeps the grant until it
// signals its last beat, drops its request, or runs into the hold limit.
// Priority then rotates to the requester after the owner. All outputs are
// registered so gnt can drive a slave mux select directly.
module rr_hold_arbiter #(
  parameter int NUM      = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NUM-1:0]  req,
  input  logic [NUM-1:0]  last,
  output logic [NUM-1:0]  gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            preempt
);

  // Elaboration-time sanity checks on the parameter set.
  if (NUM < 2 || NUM > 16) begin : g_bad_num
    $error("rr_hold_arbiter: NUM must be in 2..16");
  end
  if (ID_W != $clog2(NUM)) begin : g_bad_id_w
    $error("rr_hold_arbiter: ID_W must equal clog2(NUM)");
  end
  if (MAX_HOLD < 0 || MAX_HOLD > (2**HOLD_W) - 1) begin : g_bad_hold
    $error("rr_hold_arbiter: HOLD_W too narrow for MAX_HOLD");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [NUM-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              busy_q;
  logic              preempt_q, preempt_d;
  logic [NUM-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [NUM-1:0]    ptr_next;
  logic [NUM-1:0]    win;
  logic              own_req;
  logic              own_last;
  logic              hit_limit;

  // First set bit of cand, scanning upward from the one-hot ptr with wrap.
  function automatic logic [NUM-1:0] rr_pick(input logic [NUM-1:0] cand,
                                             input logic [NUM-1:0] ptr);
    logic [NUM-1:0] pick;
    logic           found;
    int             k;
    pick  = '0;
    found = 1'b0;
    for (int s = 0; s < NUM; s++) begin
      if (ptr[s]) begin
        for (int off = 0; off < NUM; off++) begin
          k = (s + off) % NUM;
          if (!found && cand[k]) begin
            pick[k] = 1'b1;
            found   = 1'b1;
          end
        end
      end
    end
    return pick;
  endfunction

  // Binary index of a one-hot vector; zero when the vector is empty.
  function automatic logic [ID_W-1:0] to_id(input logic [NUM-1:0] onehot);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM; i++) begin
      if (onehot[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  // Next-state logic: arbitration on entry from IDLE and on every transaction end.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    win        = '0;
    ptr_next   = {gnt_q[NUM-2:0], gnt_q[NUM-1]};
    own_req    = |(gnt_q & req);
    own_last   = |(gnt_q & req & last);
    hit_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD));

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win        = rr_pick(req, ptr_q);
          gnt_d      = win;
          gnt_id_d   = to_id(win);
          state_d    = BUSY;
          hold_cnt_d = HOLD_W'(1);
        end
      end
      BUSY: begin
        if (own_last || !own_req || hit_limit) begin
          // Owner sits just below the new ptr, so it only wins if nobody else asks.
          ptr_d     = ptr_next;
          win       = rr_pick(req, ptr_next);
          preempt_d = hit_limit && own_req && !own_last;
          if (|win) begin
            gnt_d      = win;
            gnt_id_d   = to_id(win);
            hold_cnt_d = HOLD_W'(1);
          end else begin
            gnt_d      = '0;
            gnt_id_d   = '0;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end
        end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset acts immediately, even mid-transaction.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      ptr_q      <= NUM'(1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= |gnt_d;
      preempt_q  <= preempt_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (NUM=4, MAX_HOLD=16): a vector table for
// single-cycle behaviour plus hand-written hold-limit and async-reset sequences.
module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_hold_arbiter #(.NUM(4), .ID_W(2), .MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .last    (last),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] l,
                              input logic [3:0] g, input logic [1:0] id, input logic pre);
    vec_t v;
    v.rst  = rst;
    v.req  = r;
    v.last = l;
    v.gnt  = g;
    v.id   = id;
    v.busy = (g != 4'b0000);
    v.pre  = pre;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic [3:0] r_last);
    reset = r_rst;
    req   = r_req;
    last  = r_last;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    last  = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    last  = '0;
    #12;
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset gnt_id", 32'(gnt_id), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset preempt", 32'(preempt), 32'h0);
    reset = 1'b0;

    // ---- table: rst, req, last, exp gnt, exp id, exp preempt
    // plan 1: ptr at 0, 0110 -> 1; last[1] hands over to 2 without a bubble
    vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
    // plan 2: reset ptr, all request, last on each owner's 3rd cycle
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0010, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 0));
    // plan 5: non-owner last and last in IDLE are ignored
    vecs.push_back(mk(0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0110, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1000, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b1101, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 0));
    // plan 4: owner abandons, owner 2 then drops to idle, 0 granted next
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0));
    // sole requester ending with last is regranted at the same edge
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].last);
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d gnt_id", i), 32'(gnt_id), 32'(vecs[i].id));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d preempt", i), 32'(preempt), 32'(vecs[i].pre));
    end

    // plan 3: hold-limit preemption with 0011 held, then last on the limit cycle
    do_reset();
    for (int e = 1; e <= 49; e++) begin
      logic [3:0] exp_g;
      logic       exp_p;
      step(1'b0, 4'b0011, (e == 49) ? 4'b0001 : 4'b0000);
      if (e <= 16)      exp_g = 4'b0001;
      else if (e <= 32) exp_g = 4'b0010;
      else if (e <= 48) exp_g = 4'b0001;
      else              exp_g = 4'b0010;
      exp_p = (e == 17) || (e == 33);
      check($sformatf("hold e%0d gnt", e), 32'(gnt), 32'(exp_g));
      check($sformatf("hold e%0d preempt", e), 32'(preempt), 32'(exp_p));
    end

    // plan 6: move ptr away from 0, reach gnt=1000, reset mid-cycle
    do_reset();
    step(1'b0, 4'b0010, 4'b0000);
    check("r6 gnt1", 32'(gnt), 32'h2);
    step(1'b0, 4'b1000, 4'b0000);
    check("r6 gnt3", 32'(gnt), 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check("r6 async gnt", 32'(gnt), 32'h0);
    check("r6 async busy", 32'(busy), 32'h0);
    check("r6 async gnt_id", 32'(gnt_id), 32'h0);
    @(posedge clk);
    #1;
    step(1'b0, 4'b1001, 4'b0000);
    check("r6 after gnt", 32'(gnt), 32'h1);
    check("r6 after gnt_id", 32'(gnt_id), 32'h0);
    check("r6 after busy", 32'(busy), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter with grant locking, for shared resources whose transactions last several cycles.
- A granted requester keeps the resource until one of three things happens: it signals the last beat, it drops its request, or a hold-limit timer preempts it.
- Priority then rotates to the requester after the owner.
- Sits between N masters and one shared slave port; gnt is registered and drives the slave mux select directly.

Parameters:
- NUM, 4: number of requesters (2..16).
- ID_W, 2: width of gnt_id; equals ceil(log2(NUM)).
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held. 0 means no limit.
- HOLD_W, 5: width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM  per-requester request level.
- last  input  NUM  per-requester final-beat flag. Only meaningful from the current owner.
- gnt  output  NUM  registered one-hot grant; all-zero when idle.
- gnt_id  output  ID_W  binary index of the set gnt bit; 0 when idle.
- busy  output  1  high while any gnt bit is set.
- preempt  output  1  one-cycle registered pulse when a grant is ended by the hold limit.

Behaviour:
- Reset, asynchronous, effective immediately, including mid-transaction:
  - gnt=0, gnt_id=0, busy=0, preempt=0.
  - state=IDLE, hold_cnt=0.
  - Priority pointer ptr=one-hot bit 0.
- Arbitration function: the first set bit of the candidate req vector, scanning from ptr upward with wrap-around (bit NUM-1 wraps to bit 0).
- FSM states: IDLE, BUSY.
- IDLE:
  - If req==0: stay in IDLE; gnt stays 0.
  - Otherwise, at the clock edge: gnt<=winner, gnt_id<=index of winner, state<=BUSY, hold_cnt<=1.
  - Latency: req sampled high at edge k gives gnt visible after edge k (one cycle).
- BUSY, owner o (gnt[o]=1). The transaction ends at an edge if any of these holds:
  - (a) req[o]=1 and last[o]=1: normal release.
  - (b) req[o]=0: abandon; treated as a release.
  - (c) MAX_HOLD!=0, hold_cnt==MAX_HOLD, and neither (a) nor (b): forced end; preempt<=1 for exactly the next cycle.
- On end:
  - ptr<=rotate-left(gnt), i.e. the requester after o.
  - Arbitrate over the current req with the new ptr. The owner is included only if req[o]=1; it then has lowest priority.
  - If there is a winner: gnt<=winner, hold_cnt<=1, stay in BUSY. No bubble cycle.
  - If there is no winner: gnt<=0, gnt_id<=0, state<=IDLE.
- No end in BUSY: gnt unchanged; hold_cnt increments, saturating at 2^HOLD_W-1 when MAX_HOLD=0.
- last from non-owners is ignored, and last is ignored in IDLE.
- A new req arriving during BUSY never disturbs the current gnt.
- (a) and (c) in the same cycle: treated as (a); preempt stays 0.
- A sole requester that ends by last while keeping req high is regranted at the same edge; hold_cnt restarts at 1.
- NUM=1 is degenerate and unsupported; NUM≥2 is enforced by parameter check.
- Invariants the verification engineer asserts:
  - gnt is always one-hot or zero.
  - busy == |gnt.
  - gnt_id matches gnt.
  - No requester waits more than (NUM-1)*MAX_HOLD+1 cycles from req rise to gnt when MAX_HOLD!=0 and all owners keep req high.

Test Plan:
1. After reset, req=4'b0110 held at edge 1 → gnt=4'b0010, gnt_id=1 after edge 1. last[1] pulsed at edge 4 → gnt=4'b0100 after edge 4, no idle cycle.
2. req=4'b1111 constant, each owner pulses last on its 3rd granted cycle → grant order 0,1,2,3,0 with 3 cycles each; preempt never set.
3. MAX_HOLD=16, req=4'b0011 constant, last never asserted → gnt=0001 for exactly 16 cycles, then gnt=0010 with preempt=1 for one cycle; then 16 cycles later gnt=0001 again.
4. Owner 2 drops req mid-grant with req=4'b0100 only → gnt=0 and busy=0 the next cycle; preempt=0; the next request from 0 is granted after one cycle.
5. last[3] asserted while owner is 1, and last asserted in IDLE → no grant change.
6. Assert reset while gnt=4'b1000 in mid-cycle → gnt=0, busy=0 immediately, without waiting for a clock edge. After release with req=4'b1001 → gnt=4'b0001, because ptr was reset to bit 0.
